// File: rtl/usr_shift_ctrl_if.sv
// usr_shift_ctrl_if: command handshake between a command source and the shift controller
interface usr_shift_ctrl_if #(parameter int N = 4, parameter int CW = $clog2(N + 1));
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [N-1:0] cmd_data;
  logic [CW-1:0] cmd_amt;
  modport master (output cmd_valid, cmd_op, cmd_data, cmd_amt, input cmd_ready);
  modport slave (input cmd_valid, cmd_op, cmd_data, cmd_amt, output cmd_ready);
endinterface

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: sequences a universal shift register through TX-MSB, TX-LSB, RX and rotate-left commands
module usr_shift_ctrl #(parameter int N = 4) (
  input  logic clk,
  input  logic reset,
  usr_shift_ctrl_if.slave cmd,
  output logic [1:0] usr_s,
  output logic [N-1:0] usr_a,
  output logic usr_lin,
  output logic usr_rin,
  input  logic [N-1:0] usr_q,
  output logic sdo,
  output logic sdo_valid,
  input  logic sdi,
  output logic sdi_ready,
  output logic [N-1:0] rx_data,
  output logic done
);
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] TX_L = 2'b00, TX_R = 2'b01, RX_L = 2'b10, ROT = 2'b11;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [N-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d, amt_c;
  assign amt_c = (cmd.cmd_amt >= CW'(N)) ? CW'(N - 1) : cmd.cmd_amt;
  assign rx_data = usr_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  // the rotate amount is parked in cnt at acceptance so LOAD can test it for zero
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    data_d = data_q;
    cnt_d = cnt_q;
    cmd.cmd_ready = 1'b0;
    usr_s = 2'b00;
    usr_a = '0;
    usr_lin = 1'b0;
    usr_rin = 1'b0;
    sdo = 1'b0;
    sdo_valid = 1'b0;
    sdi_ready = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          op_d = cmd.cmd_op;
          data_d = cmd.cmd_data;
          cnt_d = (cmd.cmd_op == ROT) ? amt_c : CW'(N);
          state_d = (cmd.cmd_op == RX_L) ? SHIFT : LOAD;
        end
      end
      LOAD: begin
        usr_s = 2'b11;
        usr_a = data_q;
        state_d = (op_q == ROT && cnt_q == '0) ? FIN : SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIN : SHIFT;
        usr_s = (op_q == TX_R) ? 2'b10 : 2'b01;
        usr_lin = (op_q == RX_L) ? sdi : (op_q == ROT) ? usr_q[N-1] : 1'b0;
        sdo = (op_q == TX_L) ? usr_q[N-1] : (op_q == TX_R) ? usr_q[0] : 1'b0;
        sdo_valid = ~op_q[1];
        sdi_ready = (op_q == RX_L);
      end
      default: begin
        done = 1'b1;
        state_d = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_usr_shift_ctrl.sv
// tb_usr_shift_ctrl: directed and random commands against a behavioural shift register and word-level expectations
module tb_usr_shift_ctrl;
  localparam int N = 4;
  localparam int CW = $clog2(N + 1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] usr_s;
  logic [N-1:0] usr_a, usr_q, rx_data;
  logic usr_lin, usr_rin, sdo, sdo_valid, sdi, sdi_ready, done;
  int total = 0;
  int bad = 0;
  usr_shift_ctrl_if #(.N(N)) cif ();
  usr_shift_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .cmd(cif.slave),
    .usr_s(usr_s), .usr_a(usr_a), .usr_lin(usr_lin), .usr_rin(usr_rin), .usr_q(usr_q),
    .sdo(sdo), .sdo_valid(sdo_valid), .sdi(sdi), .sdi_ready(sdi_ready),
    .rx_data(rx_data), .done(done)
  );
  always #5 clk = ~clk;
  // external universal shift register driven by the controller
  initial usr_q = '0;
  always @(posedge clk)
    case (usr_s)
      2'b11: usr_q <= usr_a;
      2'b01: usr_q <= {usr_q[N-2:0], usr_lin};
      2'b10: usr_q <= {usr_rin, usr_q[N-1:1]};
      default: ;
    endcase
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_cmd(input logic [1:0] op, input logic [N-1:0] d, input logic [CW-1:0] amt,
                        input logic [N-1:0] sbits, input bit hold);
    int a, lat, bitpos;
    logic [2*N-1:0] rot;
    logic [N-1:0] exp_word;
    logic [1:0] exp_s;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op = op;
    cif.cmd_data = d;
    cif.cmd_amt = amt;
    chk("ready_idle", cif.cmd_ready, 1);
    a = (int'(amt) >= N) ? N - 1 : int'(amt);
    lat = (op == 2'b10) ? N + 1 : (op == 2'b11) ? a + 2 : N + 2;
    rot = {d, d} << a;
    exp_word = (op == 2'b10) ? sbits : (op == 2'b11) ? rot[2*N-1:N] : '0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (hold) begin
        cif.cmd_op = 2'($urandom);
        cif.cmd_data = N'($urandom);
        cif.cmd_amt = CW'($urandom);
      end else cif.cmd_valid = 1'b0;
      sdi = (op == 2'b10 && k <= N) ? sbits[N-k] : 1'($urandom);
      #1;
      chk("ready_busy", cif.cmd_ready, 0);
      chk("done", done, (k == lat) ? 1 : 0);
      exp_s = (k == lat) ? 2'b00 : (op != 2'b10 && k == 1) ? 2'b11 : (op == 2'b01) ? 2'b10 : 2'b01;
      chk("usr_s", usr_s, exp_s);
      if (op != 2'b10 && k == 1) chk("usr_a", usr_a, d);
      chk("sdo_valid", sdo_valid, (!op[1] && k >= 2 && k <= N + 1) ? 1 : 0);
      chk("sdi_ready", sdi_ready, (op == 2'b10 && k <= N) ? 1 : 0);
      if (!op[1] && k >= 2 && k <= N + 1) begin
        bitpos = (op == 2'b00) ? N - 1 - (k - 2) : k - 2;
        chk("sdo", sdo, d[bitpos]);
      end
      if (k == lat) chk("rx_data", rx_data, exp_word);
    end
  endtask
  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op = '0;
    cif.cmd_data = '0;
    cif.cmd_amt = '0;
    sdi = 1'b0;
    #2;
    chk("rst_usr_s", usr_s, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_sdo_valid", sdo_valid, 0);
    chk("rst_sdi_ready", sdi_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_cmd(2'b00, 4'b1011, 0, 0, 0);
    chk("txl_q_empty", usr_q, 0);
    do_cmd(2'b01, 4'b1011, 0, 0, 0);
    do_cmd(2'b10, 0, 0, 4'b1101, 0);
    do_cmd(2'b11, 4'b1001, 1, 0, 0);
    do_cmd(2'b11, 4'b1001, 0, 0, 0);
    do_cmd(2'b11, 4'b1000, 3, 0, 0);
    do_cmd(2'b11, 4'b0110, 6, 0, 0);
    do_cmd(2'b00, 4'b0110, 0, 0, 1);
    do_cmd(2'b01, 4'b1100, 0, 0, 0);
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op = 2'b00;
    cif.cmd_data = 4'b1111;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_usr_s", usr_s, 0);
    chk("midrst_sdo_valid", sdo_valid, 0);
    chk("midrst_ready", cif.cmd_ready, 1);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    do_cmd(2'b10, 0, 0, 4'b0110, 0);
    for (int i = 0; i < 16; i++)
      do_cmd(2'($urandom), N'($urandom), CW'($urandom_range(0, 7)), N'($urandom), 1'($urandom));
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("final_ready", cif.cmd_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
Sequencing controller for an N-bit universal shift register (modes: hold / shift-left / shift-right / parallel-load). It accepts one command at a time over a valid/ready handshake and runs one of four operations on the register: serial transmit MSB-first, serial transmit LSB-first, serial receive, or rotate-left. It drives the register's mode-select, load-data and serial-input pins, observes its parallel output, and sits between a command source and the shift-register datapath.

Parameters:
N, 4, register width in bits (N >= 2)
CW, $clog2(N+1), bit-counter and rotate-amount width (derived, do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00 TX_L, 01 TX_R, 10 RX_L, 11 ROT
cmd_data  input  N  load value for TX_L, TX_R and ROT
cmd_amt  input  CW  rotate amount for ROT, 0..N-1
usr_s  output  2  register mode: 11 load, 01 shift left, 10 shift right, 00 hold
usr_a  output  N  register parallel-load data
usr_lin  output  1  register serial input for left shift
usr_rin  output  1  register serial input for right shift
usr_q  input  N  register parallel output
sdo  output  1  serial data out
sdo_valid  output  1  sdo carries a valid bit this cycle
sdi  input  1  serial data in
sdi_ready  output  1  sdi is sampled this cycle
rx_data  output  N  received or rotated word (equals usr_q)
done  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous: state goes to IDLE and op_r, data_r and cnt go to 0 immediately, including mid-operation. All decoded outputs take their IDLE values: usr_s=00, usr_a=0, usr_lin=0, usr_rin=0, sdo_valid=0, sdi_ready=0, done=0, cmd_ready=1. The controller does not reset the register itself.
- States:
  - IDLE: cmd_ready=1, usr_s=00. On cmd_valid&&cmd_ready, capture op/data/amt. RX_L goes to SHIFT with cnt=N. All other ops go to LOAD.
  - LOAD: one cycle; usr_s=11, usr_a=data_r. Next state is SHIFT with cnt=N for TX, or cnt=amt for ROT. ROT with amt=0 goes straight to DONE.
  - SHIFT: one shift per cycle; cnt decrements each cycle. Leave for DONE in the cycle cnt==1.
  - DONE: one cycle; done=1, usr_s=00; then IDLE.
- Shift-mode decode in SHIFT:
  - TX_L: usr_s=01, usr_lin=0, sdo=usr_q[N-1], sdo_valid=1.
  - TX_R: usr_s=10, usr_rin=0, sdo=usr_q[0], sdo_valid=1.
  - RX_L: usr_s=01, usr_lin=sdi, sdi_ready=1.
  - ROT: usr_s=01, usr_lin=usr_q[N-1].
- Outside SHIFT: sdo=0, usr_lin=0, usr_rin=0.
- cmd_ready=0 in every state except IDLE. cmd_valid while busy is ignored and causes no capture.
- Latency, with acceptance in cycle T:
  - TX: LOAD at T+1, bits at T+2..T+N+1, done at T+N+2.
  - RX: samples at T+1..T+N, done at T+N+1.
  - ROT: done at T+amt+2.
  - The next command can be accepted at done+1.
- rx_data=usr_q, combinational. It is meaningful while done=1. For RX_L the first sdi bit lands in bit N-1.
- cmd_amt >= N for ROT is clamped to N-1.
- usr_s, usr_a, usr_lin, usr_rin, sdo, sdo_valid, sdi_ready and done are decoded combinationally from state and captured registers; there is no extra pipeline stage.
- The controller assumes the register's usr_q updates on the same clk edge as the controller's state.

Test Plan:
- N=4, TX_L data 1011 accepted at T -> usr_s=11 at T+1; sdo=1,0,1,1 with sdo_valid at T+2..T+5; done at T+6; usr_q=0000.
- TX_R data 1011 -> sdo=1,1,0,1 (LSB first) at T+2..T+5; done at T+6.
- RX_L with sdi=1,1,0,1 at T+1..T+4 (sdi_ready high) -> done at T+5, rx_data=1101.
- ROT data 1001 amt 1 -> done at T+3, rx_data=0011. ROT amt 0 -> LOAD then done at T+2, rx_data=1001. ROT amt 3 on 1000 -> rx_data=0100.
- cmd_valid held high through a TX_L -> cmd_ready low T+1..T+6; second command accepted at T+7 only.
- reset asserted at T+3 of a TX_L -> same cycle: usr_s=00, sdo_valid=0, cmd_ready=1; after release a new RX_L completes normally.
